fpc_arbiter: RTL and testbench
==============================

FPC_ARBITER -- requirements
Module: fpc_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 8, maximum WAIT cycles before an error response; legal range 2..255.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester 0/1 operation accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  16  requester operands.
REQ-007 req0_mode / req1_mode  input  1  0 = add, 1 = multiply.
REQ-008 fp_in_valid  output  1  one-cycle issue strobe to the shared FP unit.
REQ-009 fp_in_a, fp_in_b  output  16  operands to the FP unit.
REQ-010 fp_mode  output  1  operation select to the FP unit.
REQ-011 fp_out_valid  input  1  FP unit result strobe.
REQ-012 fp_out  input  16  FP unit result.
REQ-013 rsp0_valid / rsp1_valid  output  1  response to requester 0/1.
REQ-014 rsp_data  output  16  response result, shared by both channels.
REQ-015 rsp_err  output  1  response is a timeout (no result).
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP; one operation outstanding at a time.
REQ-018 IDLE: if either reqN_valid is high, grant one channel, assert its reqN_ready combinationally in that cycle, latch its a/b/mode and channel id, go to ISSUE; otherwise stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: when both channels are valid, grant the channel not granted last; with one valid, grant it.
REQ-020 Last-grant pointer SHALL update on each accept; after reset it SHALL equal 1, so channel 0 wins the first contention.
REQ-021 reqN_ready SHALL be 0 in every state except IDLE and SHALL never be high for both channels at once.
REQ-022 ISSUE: fp_in_valid = 1 for exactly one cycle with the latched operands on fp_in_a/fp_in_b/fp_mode; go to WAIT with timer = 0.
REQ-023 fp_in_a/fp_in_b/fp_mode SHALL hold the latched values outside ISSUE; fp_in_valid SHALL be 0 outside ISSUE.
REQ-024 WAIT: timer increments each cycle; on fp_out_valid = 1 capture fp_out into rsp_data, rsp_err = 0, go to RESP.
REQ-025 WAIT: if timer reaches TIMEOUT with no fp_out_valid, set rsp_data = 16'h0000, rsp_err = 1, go to RESP.
REQ-026 fp_out_valid in the same cycle the timer reaches TIMEOUT SHALL win (normal result, rsp_err = 0).
REQ-027 fp_out_valid outside WAIT SHALL be ignored and SHALL NOT alter rsp_data or state.
REQ-028 RESP: rspN_valid of the granted channel = 1 for exactly one cycle, other channel 0; then go to IDLE.
REQ-029 rsp_data/rsp_err SHALL hold their value until the next capture.
REQ-030 Latency with a 2-cycle FP unit: accept cycle T, fp_in_valid at T+1, fp_out_valid at T+3, rspN_valid at T+4, next accept earliest T+5.
REQ-031 Requester inputs SHALL be sampled only in the accept cycle; later changes SHALL NOT affect the operation in flight.

Reset
REQ-032 On rst_n low, asynchronously: state IDLE, last grant = 1, timer = 0, latched operands = 0, fp_in_valid/fp_in_a/fp_in_b/fp_mode = 0, rsp0_valid/rsp1_valid/rsp_data/rsp_err = 0, busy = 0.
REQ-033 Reset during ISSUE/WAIT/RESP SHALL abort the operation with no response; a late fp_out_valid after reset SHALL be ignored.

Verification
REQ-034 Single req0: a=16'h3C00, b=16'h4000, mode=0, FP unit returns 16'h4200 after 2 cycles -> req0_ready at T, fp_in_valid at T+1, rsp0_valid at T+4 with rsp_data=16'h4200, rsp_err=0.
REQ-035 Both valid from reset, held for two operations -> order ch0 then ch1; rsp0_valid precedes rsp1_valid; req ready never high on both channels.
REQ-036 FP unit never answers, TIMEOUT=8 -> rsp_err=1, rsp_data=16'h0000, rspN_valid one cycle, then IDLE; next request is served normally.
REQ-037 fp_out_valid exactly on the cycle the timer reaches TIMEOUT -> normal result, rsp_err=0.
REQ-038 rst_n pulsed low during WAIT, then fp_out_valid arrives -> no rsp valid, busy=0, all outputs 0.
REQ-039 Stray fp_out_valid in IDLE with fp_out=16'hFFFF -> rsp_data unchanged, no response.

Source files
------------

// File: rtl/fpc_arbiter_if.sv
// Handshake bundle between two requesters, the shared FP unit and the arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface fpc_arbiter_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        req0_mode;
    logic        req1_mode;
    logic        fp_in_valid;
    logic [15:0] fp_in_a;
    logic [15:0] fp_in_b;
    logic        fp_mode;
    logic        fp_out_valid;
    logic [15:0] fp_out;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_mode, req1_mode, fp_out_valid, fp_out,
        output req0_ready, req1_ready, fp_in_valid, fp_in_a, fp_in_b, fp_mode,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_err, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_mode, req1_mode, fp_out_valid, fp_out,
        input  req0_ready, req1_ready, fp_in_valid, fp_in_a, fp_in_b, fp_mode,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/fpc_arbiter.sv
// Round-robin arbiter sharing one FP unit between two requesters, one operation
// in flight, with a watchdog that returns an error response if the unit stalls.
//
// state | meaning
// IDLE  | waiting for a request; ready asserted combinationally to the winner
// ISSUE | one-cycle issue strobe to the FP unit with latched operands
// WAIT  | counting cycles until the FP result or the timeout
// RESP  | one-cycle response strobe to the granted channel
module fpc_arbiter #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    fpc_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Terminal count: the WAIT cycle whose increment brings the timer to TIMEOUT.
    localparam logic [7:0] TERM = 8'(TIMEOUT - 1);

    state_t      state;
    logic        last_grant;
    logic        chan;
    logic [7:0]  timer;
    logic [15:0] lat_a;
    logic [15:0] lat_b;
    logic        lat_mode;
    logic        fp_in_valid_q;
    logic        rsp0_valid_q;
    logic        rsp1_valid_q;
    logic [15:0] rsp_data_q;
    logic        rsp_err_q;
    logic        grant0;
    logic        grant1;

    assign grant0 = (state == IDLE) && bus.req0_valid && (!bus.req1_valid || last_grant);
    assign grant1 = (state == IDLE) && bus.req1_valid && !grant0;

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.fp_in_valid = fp_in_valid_q;
    assign bus.fp_in_a     = lat_a;
    assign bus.fp_in_b     = lat_b;
    assign bus.fp_mode     = lat_mode;
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            chan          <= 1'b0;
            timer         <= 8'd0;
            lat_a         <= 16'h0000;
            lat_b         <= 16'h0000;
            lat_mode      <= 1'b0;
            fp_in_valid_q <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp_data_q    <= 16'h0000;
            rsp_err_q     <= 1'b0;
        end else begin
            fp_in_valid_q <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        lat_a         <= grant1 ? bus.req1_a    : bus.req0_a;
                        lat_b         <= grant1 ? bus.req1_b    : bus.req0_b;
                        lat_mode      <= grant1 ? bus.req1_mode : bus.req0_mode;
                        chan          <= grant1;
                        last_grant    <= grant1;
                        fp_in_valid_q <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= 8'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 8'd1;
                    // A result arriving on the terminal cycle still counts as a result.
                    if (bus.fp_out_valid) begin
                        rsp_data_q   <= bus.fp_out;
                        rsp_err_q    <= 1'b0;
                        rsp0_valid_q <= !chan;
                        rsp1_valid_q <= chan;
                        state        <= RESP;
                    end else if (timer == TERM) begin
                        rsp_data_q   <= 16'h0000;
                        rsp_err_q    <= 1'b1;
                        rsp0_valid_q <= !chan;
                        rsp1_valid_q <= chan;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpc_arbiter.sv
// Self-checking bench for fpc_arbiter: directed scenarios plus a randomized run
// checked against a cycle-count model derived from the arbitration and timeout rules.
module tb_fpc_arbiter;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    fpc_arbiter_if bus();

    fpc_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural FP unit: answers fp_lat cycles after the issue strobe (0 = never).
    int          fp_lat = 2;
    bit          fixed_en = 1'b0;
    logic [15:0] fixed_val = 16'h0000;
    int          cnt = 0;
    logic        resp_fire = 1'b0;
    logic [15:0] resp_val = 16'h0000;
    logic        man_valid = 1'b0;
    logic [15:0] man_data = 16'h0000;

    assign bus.fp_out_valid = resp_fire | man_valid;
    assign bus.fp_out       = man_valid ? man_data : resp_val;

    function automatic logic [15:0] fp_model(input logic [15:0] a, input logic [15:0] b, input logic m);
        logic [31:0] p;
        p = a * b;
        return m ? p[15:0] : 16'(a + b);
    endfunction

    always @(posedge clk) begin
        #1;
        resp_fire = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) resp_fire = 1'b1;
        end
        if (bus.fp_in_valid && fp_lat > 0) begin
            cnt = fp_lat;
            resp_val = fixed_en ? fixed_val : fp_model(bus.fp_in_a, bus.fp_in_b, bus.fp_mode);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (bus.req0_ready && bus.req1_ready) begin
                errors++;
                $display("FAIL ready_exclusive: ready0=%b ready1=%b, required not both at %0t",
                         bus.req0_ready, bus.req1_ready, $time);
            end
            checks++;
            if (bus.rsp0_valid && bus.rsp1_valid) begin
                errors++;
                $display("FAIL rsp_exclusive: rsp0=%b rsp1=%b, required not both at %0t",
                         bus.rsp0_valid, bus.rsp1_valid, $time);
            end
        end
    end

    logic [55:0] all_outs;
    assign all_outs = {bus.fp_in_valid, bus.fp_in_a, bus.fp_in_b, bus.fp_mode,
                       bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data, bus.rsp_err,
                       bus.busy, bus.req0_ready, bus.req1_ready};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_req(input logic v0, input logic [15:0] a0, input logic [15:0] b0, input logic m0,
                           input logic v1, input logic [15:0] a1, input logic [15:0] b1, input logic m1);
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_mode = m0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_mode = m1;
    endtask

    // Steps from the issue cycle until a response strobe; n counts cycles after issue.
    task automatic wait_rsp(output int n);
        n = -1;
        for (int i = 1; i <= TO + 6 && n < 0; i++) begin
            step();
            sample();
            if (bus.rsp0_valid || bus.rsp1_valid) n = i;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step();
        sample();
        checks++;
        if (all_outs !== 56'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", all_outs);
        end
        step();
        rst_n = 1'b1;
        sample();
        checks++;
        if ({bus.busy, bus.req0_ready, bus.req1_ready, bus.fp_in_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: busy/ready0/ready1/fp_in_valid=%b, required 0000",
                     {bus.busy, bus.req0_ready, bus.req1_ready, bus.fp_in_valid});
        end
    endtask

    task automatic test_contention();
        int n;
        fp_lat = 2; fixed_en = 1'b0;
        step();
        set_req(1, 16'h1234, 16'h0101, 0, 1, 16'h00F3, 16'h0021, 1);
        sample();
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL cont_first_grant: ready1/ready0=%b, required 01", {bus.req1_ready, bus.req0_ready});
        end
        step();
        sample();
        checks++;
        if ({bus.fp_in_valid, bus.fp_in_a, bus.fp_in_b, bus.fp_mode, bus.req0_ready, bus.req1_ready}
            !== {1'b1, 16'h1234, 16'h0101, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL cont_issue0: valid=%b a=%h b=%h mode=%b, required 1 1234 0101 0",
                     bus.fp_in_valid, bus.fp_in_a, bus.fp_in_b, bus.fp_mode);
        end
        wait_rsp(n);
        checks++;
        if (n !== 3 || {bus.rsp1_valid, bus.rsp0_valid} !== 2'b01 || bus.rsp_data !== 16'h1335 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL cont_rsp0: n=%0d rsp1/0=%b data=%h err=%b, required 3 01 1335 0",
                     n, {bus.rsp1_valid, bus.rsp0_valid}, bus.rsp_data, bus.rsp_err);
        end
        step();
        sample();
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL cont_second_grant: ready1/ready0=%b, required 10", {bus.req1_ready, bus.req0_ready});
        end
        step();
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        checks++;
        if ({bus.fp_in_valid, bus.fp_in_a, bus.fp_in_b, bus.fp_mode} !== {1'b1, 16'h00F3, 16'h0021, 1'b1}) begin
            errors++;
            $display("FAIL cont_issue1: valid=%b a=%h b=%h mode=%b, required 1 00f3 0021 1",
                     bus.fp_in_valid, bus.fp_in_a, bus.fp_in_b, bus.fp_mode);
        end
        wait_rsp(n);
        checks++;
        if (n !== 3 || {bus.rsp1_valid, bus.rsp0_valid} !== 2'b10 || bus.rsp_data !== 16'h1F53) begin
            errors++;
            $display("FAIL cont_rsp1: n=%0d rsp1/0=%b data=%h, required 3 10 1f53",
                     n, {bus.rsp1_valid, bus.rsp0_valid}, bus.rsp_data);
        end
    endtask

    task automatic test_single();
        int n;
        fp_lat = 2; fixed_en = 1'b1; fixed_val = 16'h4200;
        step();
        set_req(1, 16'h3C00, 16'h4000, 0, 0, 0, 0, 0);
        sample();
        checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.busy} !== 3'b100) begin
            errors++;
            $display("FAIL single_accept: ready0/ready1/busy=%b, required 100", {bus.req0_ready, bus.req1_ready, bus.busy});
        end
        step();
        set_req(0, 16'hDEAD, 16'hBEEF, 1, 0, 0, 0, 0);
        sample();
        checks++;
        if ({bus.fp_in_valid, bus.fp_in_a, bus.fp_in_b, bus.fp_mode} !== {1'b1, 16'h3C00, 16'h4000, 1'b0}) begin
            errors++;
            $display("FAIL single_issue: valid=%b a=%h b=%h mode=%b, required 1 3c00 4000 0",
                     bus.fp_in_valid, bus.fp_in_a, bus.fp_in_b, bus.fp_mode);
        end
        step();
        sample();
        checks++;
        if ({bus.fp_in_valid, bus.fp_in_a, bus.busy} !== {1'b0, 16'h3C00, 1'b1}) begin
            errors++;
            $display("FAIL single_hold: valid=%b a=%h busy=%b, required 0 3c00 1", bus.fp_in_valid, bus.fp_in_a, bus.busy);
        end
        wait_rsp(n);
        checks++;
        if (n !== 2 || {bus.rsp1_valid, bus.rsp0_valid} !== 2'b01 || bus.rsp_data !== 16'h4200 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: n=%0d rsp1/0=%b data=%h err=%b, required 2 01 4200 0",
                     n, {bus.rsp1_valid, bus.rsp0_valid}, bus.rsp_data, bus.rsp_err);
        end
        step();
        sample();
        checks++;
        if ({bus.rsp0_valid, bus.rsp1_valid, bus.busy} !== 3'b000) begin
            errors++;
            $display("FAIL single_done: rsp0/rsp1/busy=%b, required 000", {bus.rsp0_valid, bus.rsp1_valid, bus.busy});
        end
        fixed_en = 1'b0;
    endtask

    task automatic test_stray();
        step();
        man_valid = 1'b1; man_data = 16'hFFFF;
        sample();
        checks++;
        if ({bus.busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin
            errors++;
            $display("FAIL stray_idle: busy/rsp0/rsp1=%b, required 000", {bus.busy, bus.rsp0_valid, bus.rsp1_valid});
        end
        step();
        man_valid = 1'b0;
        sample();
        checks++;
        if ({bus.rsp_data, bus.rsp_err, bus.rsp0_valid, bus.rsp1_valid, bus.busy} !== {16'h4200, 4'b0000}) begin
            errors++;
            $display("FAIL stray_hold: data=%h err=%b rsp0/rsp1/busy=%b, required 4200 0 000",
                     bus.rsp_data, bus.rsp_err, {bus.rsp0_valid, bus.rsp1_valid, bus.busy});
        end
    endtask

    task automatic test_timeout();
        int n;
        fp_lat = 0;
        step();
        set_req(0, 0, 0, 0, 1, 16'h0007, 16'h0009, 1);
        sample();
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL tmo_grant: ready1/ready0=%b, required 10", {bus.req1_ready, bus.req0_ready});
        end
        step();
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        wait_rsp(n);
        checks++;
        if (n !== TO + 1 || {bus.rsp1_valid, bus.rsp0_valid} !== 2'b10 || bus.rsp_data !== 16'h0000 || bus.rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_rsp: n=%0d rsp1/0=%b data=%h err=%b, required %0d 10 0000 1",
                     n, {bus.rsp1_valid, bus.rsp0_valid}, bus.rsp_data, bus.rsp_err, TO + 1);
        end
        step();
        sample();
        checks++;
        if ({bus.rsp0_valid, bus.rsp1_valid, bus.busy} !== 3'b000) begin
            errors++;
            $display("FAIL tmo_idle: rsp0/rsp1/busy=%b, required 000", {bus.rsp0_valid, bus.rsp1_valid, bus.busy});
        end
        fp_lat = 3;
        step();
        set_req(1, 16'h0010, 16'h0020, 0, 0, 0, 0, 0);
        sample();
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL tmo_next_grant: ready1/ready0=%b, required 01", {bus.req1_ready, bus.req0_ready});
        end
        step();
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        wait_rsp(n);
        checks++;
        if (n !== 4 || bus.rsp0_valid !== 1'b1 || bus.rsp_data !== 16'h0030 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_next_rsp: n=%0d rsp0=%b data=%h err=%b, required 4 1 0030 0",
                     n, bus.rsp0_valid, bus.rsp_data, bus.rsp_err);
        end
    endtask

    task automatic test_boundary();
        int n;
        logic [15:0] exp_d;
        logic exp_e;
        for (int lat = TO; lat <= TO + 1; lat++) begin
            fp_lat = lat;
            exp_e = (lat > TO);
            exp_d = exp_e ? 16'h0000 : fp_model(16'h0123, 16'h0456, 1'b0);
            step();
            set_req(1, 16'h0123, 16'h0456, 0, 0, 0, 0, 0);
            sample();
            step();
            set_req(0, 0, 0, 0, 0, 0, 0, 0);
            sample();
            wait_rsp(n);
            checks++;
            if (n !== TO + 1 || bus.rsp0_valid !== 1'b1 || bus.rsp_data !== exp_d || bus.rsp_err !== exp_e) begin
                errors++;
                $display("FAIL boundary_lat%0d: n=%0d rsp0=%b data=%h err=%b, required %0d 1 %h %b",
                         lat, n, bus.rsp0_valid, bus.rsp_data, bus.rsp_err, TO + 1, exp_d, exp_e);
            end
            step();
            sample();
            checks++;
            if ({bus.rsp_data, bus.rsp_err, bus.rsp0_valid, bus.busy} !== {exp_d, exp_e, 2'b00}) begin
                errors++;
                $display("FAIL boundary_after%0d: data=%h err=%b rsp0=%b busy=%b, required %h %b 0 0",
                         lat, bus.rsp_data, bus.rsp_err, bus.rsp0_valid, bus.busy, exp_d, exp_e);
            end
        end
    endtask

    task automatic test_random();
        int n, lat, win, exp_n, m_last;
        logic [1:0] v;
        logic [15:0] a0, b0, a1, b1, wa, wb, exp_d;
        logic m0, m1, wm, exp_e;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_last = 1;
        for (int it = 0; it < 40; it++) begin
            v = 2'($urandom_range(1, 3));
            a0 = 16'($urandom); b0 = 16'($urandom); m0 = 1'($urandom);
            a1 = 16'($urandom); b1 = 16'($urandom); m1 = 1'($urandom);
            lat = $urandom_range(1, TO + 2);
            fp_lat = lat;
            win = (v == 2'b11) ? (m_last == 1 ? 0 : 1) : (v[0] ? 0 : 1);
            m_last = win;
            wa = (win == 0) ? a0 : a1;
            wb = (win == 0) ? b0 : b1;
            wm = (win == 0) ? m0 : m1;
            exp_e = (lat > TO);
            exp_d = exp_e ? 16'h0000 : fp_model(wa, wb, wm);
            exp_n = exp_e ? TO + 1 : lat + 1;
            step();
            set_req(v[0], a0, b0, m0, v[1], a1, b1, m1);
            sample();
            checks++;
            if ({bus.req1_ready, bus.req0_ready} !== ((win == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL rnd_grant it=%0d: ready1/ready0=%b, required channel %0d", it,
                         {bus.req1_ready, bus.req0_ready}, win);
            end
            step();
            set_req(0, 16'($urandom), 16'($urandom), 1'($urandom), 0, 16'($urandom), 16'($urandom), 1'($urandom));
            sample();
            checks++;
            if ({bus.fp_in_valid, bus.fp_in_a, bus.fp_in_b, bus.fp_mode} !== {1'b1, wa, wb, wm}) begin
                errors++;
                $display("FAIL rnd_issue it=%0d: valid=%b a=%h b=%h mode=%b, required 1 %h %h %b", it,
                         bus.fp_in_valid, bus.fp_in_a, bus.fp_in_b, bus.fp_mode, wa, wb, wm);
            end
            wait_rsp(n);
            checks++;
            if (n !== exp_n || {bus.rsp1_valid, bus.rsp0_valid} !== ((win == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL rnd_rsp_timing it=%0d: n=%0d rsp1/0=%b, required %0d channel %0d", it,
                         n, {bus.rsp1_valid, bus.rsp0_valid}, exp_n, win);
            end
            checks++;
            if ({bus.rsp_data, bus.rsp_err} !== {exp_d, exp_e}) begin
                errors++;
                $display("FAIL rnd_rsp_data it=%0d: data=%h err=%b, required %h %b", it,
                         bus.rsp_data, bus.rsp_err, exp_d, exp_e);
            end
            step();
            sample();
            checks++;
            if ({bus.rsp1_valid, bus.rsp0_valid, bus.busy} !== 3'b000) begin
                errors++;
                $display("FAIL rnd_done it=%0d: rsp1/rsp0/busy=%b, required 000", it,
                         {bus.rsp1_valid, bus.rsp0_valid, bus.busy});
            end
        end
    endtask

    task automatic test_reset_mid();
        fp_lat = 5;
        step();
        set_req(1, 16'h0A0A, 16'h0505, 0, 0, 0, 0, 0);
        sample();
        step();
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        step();
        step();
        rst_n = 1'b0;
        sample();
        checks++;
        if (all_outs !== 56'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h, required 0", all_outs);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample();
            checks++;
            if (all_outs !== 56'h0) begin
                errors++;
                $display("FAIL midreset_after cyc=%0d: got %h, required 0", i, all_outs);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_stray();
        test_timeout();
        test_boundary();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
